// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the IF/ID and ID/EX pipeline registers: load-use stalls,
// multi-cycle branch flush sequencing, memory-wait freeze and saturating event counters.
module hazard_ctrl_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] memwait_count
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [2:0] FCNT_LOAD   = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nx;
  logic [2:0] fcnt, fcnt_nx;
  logic       load_use;
  logic       inc_stall, inc_flush, inc_memwait;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Producer in ID/EX is a load whose destination is read by the ID instruction.
  always_comb begin
    load_use = ex_MemRead && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

  // Next-state and Mealy control decode, strict priority from reset down to normal flow.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    state_nx     = state;
    fcnt_nx      = fcnt;
    inc_stall    = 1'b0;
    inc_flush    = 1'b0;
    inc_memwait  = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nx     = RUN;
      fcnt_nx      = 3'd0;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      inc_memwait = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      inc_flush    = 1'b1;
      if (MULTI_FLUSH) begin
        state_nx = FLUSH;
        fcnt_nx  = FCNT_LOAD;
      end else begin
        state_nx = RUN;
        fcnt_nx  = 3'd0;
      end
    end else begin
      case (state)
        FLUSH: begin
          // Squashing the ID instruction, so any load-use match is irrelevant here.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (fcnt == 3'd1) begin
            state_nx = RUN;
            fcnt_nx  = 3'd0;
          end else begin
            fcnt_nx = fcnt - 3'd1;
          end
        end
        RUN: begin
          if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            inc_stall    = 1'b1;
          end else begin
            inc_stall = 1'b0;
          end
        end
        default: begin
          state_nx = RUN;
          fcnt_nx  = 3'd0;
        end
      endcase
    end
  end

  // State and flush-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count   <= {CNT_W{1'b0}};
      flush_count   <= {CNT_W{1'b0}};
      memwait_count <= {CNT_W{1'b0}};
    end else begin
      if (inc_stall)   stall_count   <= sat_inc(stall_count);
      if (inc_flush)   flush_count   <= sat_inc(flush_count);
      if (inc_memwait) memwait_count <= sat_inc(memwait_count);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit: default instance plus a 4-bit
// counter instance sharing the same stimulus for the saturation check.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_MemRead, branch_taken, mem_busy;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic [15:0] stall_count, flush_count, memwait_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_bubble;
  logic [3:0]  s_stall_count, s_flush_count, s_memwait_count;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}
  localparam logic [4:0] C_RST   = 5'b00111;
  localparam logic [4:0] C_RUN   = 5'b11010;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_FRZ   = 5'b00000;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .stall_count(stall_count), .flush_count(flush_count), .memwait_count(memwait_count)
  );

  hazard_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_write(s_id_ex_write), .id_ex_bubble(s_id_ex_bubble),
    .stall_count(s_stall_count), .flush_count(s_flush_count), .memwait_count(s_memwait_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                       input logic br, input logic busy);
    rst = r; ex_MemRead = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs2 = uses; branch_taken = br; mem_busy = busy;
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check the combinational controls mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [4:0] exp);
    @(negedge clk);
    check(tag, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble},
          {27'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("rst_c0", C_RST);
    cyc("rst_c1", C_RST);
    check("rst_stall", 32'(stall_count), 32'd0);
    check("rst_flush", 32'(flush_count), 32'd0);
    check("rst_memwait", 32'(memwait_count), 32'd0);
    quiet();
    cyc("run_quiet", C_RUN);

    // Load-use on rs2, then the producer moves on
    drive(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("lu_rs2", C_STALL);
    drive(1'b0, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("lu_rs2_after", C_RUN);
    check("lu_rs2_cnt", 32'(stall_count), 32'd1);
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("lu_rd0", C_RUN);
    drive(1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("lu_no_rs2", C_RUN);
    check("lu_none_cnt", 32'(stall_count), 32'd1);
    drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs1", C_STALL);
    check("lu_rs1_cnt", 32'(stall_count), 32'd2);

    // Single branch: two squash cycles
    quiet(); branch_taken = 1'b1;
    cyc("br_t0", C_FLUSH);
    quiet();
    cyc("br_t1", C_FLUSH);
    cyc("br_t2", C_RUN);
    check("br_cnt", 32'(flush_count), 32'd1);

    // Back-to-back branch restarts the flush
    branch_taken = 1'b1;
    cyc("bb_t0", C_FLUSH);
    cyc("bb_t1", C_FLUSH);
    quiet();
    cyc("bb_t2", C_FLUSH);
    cyc("bb_t3", C_RUN);
    check("bb_cnt", 32'(flush_count), 32'd3);

    // Freeze while in FLUSH with fcnt==1
    branch_taken = 1'b1;
    cyc("fz_br", C_FLUSH);
    quiet(); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc("fz_hold", C_FRZ);
    quiet();
    cyc("fz_resume", C_FLUSH);
    cyc("fz_done", C_RUN);
    check("fz_memwait", 32'(memwait_count), 32'd3);
    check("fz_flushcnt", 32'(flush_count), 32'd4);

    // Branch beats load-use; load-use ignored during FLUSH
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("pri_br_lu", C_FLUSH);
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("pri_lu_in_flush", C_FLUSH);
    quiet();
    cyc("pri_back_run", C_RUN);
    check("pri_stall_cnt", 32'(stall_count), 32'd2);
    check("pri_flush_cnt", 32'(flush_count), 32'd5);

    // Freeze beats branch; branch held until mem_busy drops
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("pri_busy_br", C_FRZ);
    check("pri_busy_flushcnt", 32'(flush_count), 32'd5);
    check("pri_busy_memwait", 32'(memwait_count), 32'd4);
    mem_busy = 1'b0;
    cyc("pri_br_release", C_FLUSH);
    quiet();
    cyc("pri_br_t1", C_FLUSH);
    cyc("pri_br_t2", C_RUN);
    check("pri_release_cnt", 32'(flush_count), 32'd6);

    // Reset mid-FLUSH
    branch_taken = 1'b1;
    cyc("mid_br", C_FLUSH);
    quiet(); rst = 1'b1;
    cyc("mid_rst", C_RST);
    quiet();
    cyc("mid_after", C_RUN);
    check("mid_stall", 32'(stall_count), 32'd0);
    check("mid_flush", 32'(flush_count), 32'd0);
    check("mid_memwait", 32'(memwait_count), 32'd0);

    // Saturation of the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("sat_stall", C_STALL);
      quiet();
      cyc("sat_gap", C_RUN);
      if (i == 14) check("sat_at15", 32'(s_stall_count), 32'd15);
    end
    check("sat_hold", 32'(s_stall_count), 32'd15);
    check("sat_wide", 32'(stall_count), 32'd20);
    check("sat_flush", 32'(s_flush_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
